wb_decode_bridge: RTL and testbench
===================================

WB_DECODE_BRIDGE -- requirements
Module: wb_decode_bridge

Interface
REQ-001 Parameter NSLAVE, 4, number of slave ports (1..16).
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter AW, 32, address width.
REQ-004 Parameter SEL_LSB, 16, lowest address bit of 4-bit slave-select field m_addr[SEL_LSB+3:SEL_LSB].
REQ-005 Parameter TIMEOUT, 255, max cycles waiting for slave ack (1..65535).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 m_stb  in  1  master strobe, held high until m_ack or m_err seen.
REQ-009 m_we  in  1  master write enable.
REQ-010 m_addr  in  AW  master address.
REQ-011 m_dat_i  in  DW  master write data.
REQ-012 m_dat_o  out  DW  read data returned to master.
REQ-013 m_ack  out  1  one-cycle transfer-complete pulse.
REQ-014 m_err  out  1  one-cycle transfer-failed pulse (bad decode or timeout).
REQ-015 s_stb  out  NSLAVE  one-hot slave strobe.
REQ-016 s_we  out  1  write enable broadcast to slaves.
REQ-017 s_addr  out  AW  latched address broadcast to slaves.
REQ-018 s_dat_o  out  DW  latched write data broadcast to slaves.
REQ-019 s_dat_i  in  NSLAVE*DW  slave read data, slave k at bits [k*DW+DW-1:k*DW].
REQ-020 s_ack  in  NSLAVE  slave acks.
REQ-021 err_cnt  out  8  saturating count of m_err pulses.

Function
REQ-022 States IDLE, ACTIVE, RESP; all outputs registered.
REQ-023 IDLE: m_stb high -> latch m_addr/m_we/m_dat_i into s_addr/s_we/s_dat_o, compute idx = select field.
REQ-024 IDLE, idx < NSLAVE -> s_stb[idx]=1 next cycle, timeout counter cleared, go ACTIVE.
REQ-025 IDLE, idx >= NSLAVE -> no s_stb, m_err=1 next cycle, go RESP.
REQ-026 ACTIVE: s_stb held; counter increments each cycle; only s_ack[idx] honoured, other acks ignored.
REQ-027 ACTIVE, s_ack[idx]=1 -> s_stb=0, m_dat_o = slice idx of s_dat_i (reads; unchanged on writes), m_ack=1 next cycle, go RESP.
REQ-028 ACTIVE, counter reaches TIMEOUT with no ack -> s_stb=0, m_err=1 next cycle, go RESP.
REQ-029 s_ack[idx] arriving on the same cycle the counter reaches TIMEOUT -> ack wins, m_ack not m_err.
REQ-030 RESP: m_ack/m_err high exactly one cycle, then cleared; return to IDLE; m_stb ignored in RESP.
REQ-031 Minimum read/write latency: m_stb cycle 0, s_stb cycle 1, slave ack cycle 1 -> m_ack cycle 2.
REQ-032 m_ack and m_err never high together; s_stb at most one bit high.
REQ-033 err_cnt increments on each m_err pulse; holds at 255.
REQ-034 m_dat_o holds last read value until next successful read.

Reset
REQ-035 reset high (any state, any time) -> state IDLE, s_stb=0, s_we=0, m_ack=0, m_err=0, m_dat_o=0, s_addr=0, s_dat_o=0, err_cnt=0, counter=0.
REQ-036 Reset released mid-transfer -> no m_ack/m_err for aborted transfer; next m_stb starts fresh.

Verification
REQ-037 Read slave 1 (addr 0x0001_0004), slave acks 1 cycle after s_stb with 0xDEADBEEF -> s_stb=4'b0010 for one cycle, m_dat_o=0xDEADBEEF, m_ack pulse 2 cycles after m_stb.
REQ-038 Write slave 0 addr 0x0000_0010 data 0x12345678 -> s_stb[0]=1, s_we=1, s_dat_o=0x12345678, m_ack one pulse, m_dat_o unchanged.
REQ-039 Address 0x0005_0000 with NSLAVE=4 -> no s_stb, m_err one pulse, err_cnt=1.
REQ-040 Slave 2 never acks, TIMEOUT=8 -> s_stb[2] high 8 cycles then low, m_err pulse, err_cnt increments; s_ack[3] asserted meanwhile has no effect.
REQ-041 Assert reset while in ACTIVE with s_stb[1]=1 -> all outputs 0 immediately; no m_ack after release.
REQ-042 300 bad-decode transfers -> err_cnt saturates at 255.

Source files
------------

// File: rtl/wb_decode_bridge.sv
// Wishbone-style single-master to NSLAVE-slave bridge: decodes a 4-bit select field,
// forwards one transfer at a time, and returns ack, data or an error (bad decode/timeout).
module wb_decode_bridge #(
   parameter int NSLAVE  = 4,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int SEL_LSB = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m_stb,
   input  logic                 m_we,
   input  logic [AW-1:0]        m_addr,
   input  logic [DW-1:0]        m_dat_i,
   output logic [DW-1:0]        m_dat_o,
   output logic                 m_ack,
   output logic                 m_err,
   output logic [NSLAVE-1:0]    s_stb,
   output logic                 s_we,
   output logic [AW-1:0]        s_addr,
   output logic [DW-1:0]        s_dat_o,
   input  logic [NSLAVE*DW-1:0] s_dat_i,
   input  logic [NSLAVE-1:0]    s_ack,
   output logic [7:0]           err_cnt
);

   localparam int IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t            state_q, state_d;
   logic [NSLAVE-1:0] s_stb_q, s_stb_d;
   logic              s_we_q, s_we_d;
   logic [AW-1:0]     s_addr_q, s_addr_d;
   logic [DW-1:0]     s_dat_o_q, s_dat_o_d;
   logic [DW-1:0]     m_dat_o_q, m_dat_o_d;
   logic              m_ack_q, m_ack_d;
   logic              m_err_q, m_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;

   logic [3:0]        sel;
   logic              sel_ok;
   logic              ack_hit;
   logic [DW-1:0]     rd_sel;
   logic [16:0]       cnt_inc;

   assign sel     = m_addr[SEL_LSB +: 4];
   assign sel_ok  = ({1'b0, sel} < 5'(NSLAVE));
   assign cnt_inc = {1'b0, cnt_q} + 17'd1;

   // Only the addressed slave's ack and data are looked at; the rest are ignored.
   always_comb begin
      ack_hit = 1'b0;
      rd_sel  = '0;
      for (int k = 0; k < NSLAVE; k++) begin
         if (idx_q == IW'(k)) begin
            ack_hit = s_ack[k];
            rd_sel  = s_dat_i[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      s_stb_d   = s_stb_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_dat_o_d = s_dat_o_q;
      m_dat_o_d = m_dat_o_q;
      m_ack_d   = 1'b0;
      m_err_d   = 1'b0;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (m_stb) begin
               s_addr_d  = m_addr;
               s_we_d    = m_we;
               s_dat_o_d = m_dat_i;
               idx_d     = sel[IW-1:0];
               cnt_d     = '0;
               if (sel_ok) begin
                  for (int k = 0; k < NSLAVE; k++) s_stb_d[k] = (sel == 4'(k));
                  state_d = ACTIVE;
               end else begin
                  m_err_d = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACTIVE: begin
            // An ack in the final counted cycle still beats the timeout.
            if (ack_hit) begin
               s_stb_d = '0;
               m_ack_d = 1'b1;
               if (!s_we_q) m_dat_o_d = rd_sel;
               state_d = RESP;
            end else if (cnt_inc == TO_LIM) begin
               s_stb_d = '0;
               m_err_d = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_inc[15:0];
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            s_stb_d = '0;
         end
      endcase

      if (m_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         s_stb_q   <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_dat_o_q <= '0;
         m_dat_o_q <= '0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         err_cnt_q <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         s_stb_q   <= s_stb_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_dat_o_q <= s_dat_o_d;
         m_dat_o_q <= m_dat_o_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         err_cnt_q <= err_cnt_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign s_stb   = s_stb_q;
   assign s_we    = s_we_q;
   assign s_addr  = s_addr_q;
   assign s_dat_o = s_dat_o_q;
   assign m_dat_o = m_dat_o_q;
   assign m_ack   = m_ack_q;
   assign m_err   = m_err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_wb_decode_bridge.sv
// Bench for wb_decode_bridge: directed and randomized transfers scored against a
// transaction-level model of expected outcome, latency, slave strobe and counters.
module tb_wb_decode_bridge;

   localparam int NS = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          m_stb = 1'b0;
   logic          m_we = 1'b0;
   logic [31:0]   m_addr = '0;
   logic [31:0]   m_dat_i = '0;
   logic [31:0]   m_dat_o;
   logic          m_ack;
   logic          m_err;
   logic [NS-1:0] s_stb;
   logic          s_we;
   logic [31:0]   s_addr;
   logic [31:0]   s_dat_o;
   logic [NS*32-1:0] s_dat_i = '0;
   logic [NS-1:0] s_ack = '0;
   logic [7:0]    err_cnt;

   int tests = 0;
   int fails = 0;
   logic [31:0] mdat_model = '0;
   int errcnt_model = 0;

   wb_decode_bridge #(.NSLAVE(NS), .DW(32), .AW(32), .SEL_LSB(16), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
      .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
      .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack(s_ack), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stb"}, 64'(s_stb), 64'd0);
      chk({tag, "_we"}, 64'(s_we), 64'd0);
      chk({tag, "_ack"}, 64'(m_ack), 64'd0);
      chk({tag, "_err"}, 64'(m_err), 64'd0);
      chk({tag, "_mdat"}, 64'(m_dat_o), 64'd0);
      chk({tag, "_saddr"}, 64'(s_addr), 64'd0);
      chk({tag, "_sdat"}, 64'(s_dat_o), 64'd0);
      chk({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
   endtask

   // One master transfer; the bench plays the slave, acking after 'delay' strobe cycles
   // (never, if delay >= TO) and driving 'noise' acks on slaves other than the target.
   task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input int delay, input logic [31:0] rd, input logic [3:0] noise);
      int idx, n, stb_cycles, done_n, exp_n, exp_stb;
      logic exp_ack, got_ack, got_err, done, bad_stb, bad_bus;
      logic [NS-1:0] onehot;
      idx     = int'(addr[19:16]);
      onehot  = (idx < NS) ? NS'(1 << idx) : '0;
      exp_ack = (idx < NS) && (delay < TO);
      exp_n   = (idx >= NS) ? 1 : (exp_ack ? 2 + delay : 1 + TO);
      exp_stb = (idx >= NS) ? 0 : (exp_ack ? delay + 1 : TO);
      @(negedge clk);
      m_stb = 1'b1; m_we = we; m_addr = addr; m_dat_i = wd; s_ack = '0;
      for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = (k == idx) ? rd : $urandom;
      n = 0; stb_cycles = 0; done = 1'b0; done_n = -1;
      got_ack = 1'b0; got_err = 1'b0; bad_stb = 1'b0; bad_bus = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         s_ack = '0;
         if (s_stb != '0) begin
            if (s_stb !== onehot) bad_stb = 1'b1;
            if (s_we !== we || s_addr !== addr || s_dat_o !== wd) bad_bus = 1'b1;
            if (stb_cycles == delay) s_ack = onehot;
            s_ack = s_ack | (noise & ~onehot);
            stb_cycles++;
         end
         if (m_ack || m_err) begin
            got_ack = m_ack; got_err = m_err; done_n = n; done = 1'b1;
            m_stb = 1'b0; s_ack = '0;
         end
      end
      if (exp_ack && !we) mdat_model = rd;
      if (!exp_ack && errcnt_model < 255) errcnt_model++;
      chk("done_cycle", 64'(done_n), 64'(exp_n));
      chk("m_ack", 64'(got_ack), 64'(exp_ack));
      chk("m_err", 64'(got_err), 64'(!exp_ack));
      chk("stb_cycles", 64'(stb_cycles), 64'(exp_stb));
      chk("stb_onehot", 64'(bad_stb), 64'd0);
      chk("bus_fields", 64'(bad_bus), 64'd0);
      chk("m_dat_o", 64'(m_dat_o), 64'(mdat_model));
      chk("err_cnt", 64'(err_cnt), 64'(errcnt_model));
      @(negedge clk);
      chk("resp_pulse_clear", 64'({m_ack, m_err}), 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      int d;
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      xfer(32'h0001_0004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 4'b0000);
      xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 2, 32'hCAFE_F00D, 4'b0000);
      xfer(32'h0005_0000, 1'b0, 32'h0, 0, 32'h0, 4'b0000);
      xfer(32'h0002_0000, 1'b0, 32'h0, 100, 32'h5555_AAAA, 4'b1000);
      xfer(32'h0003_0008, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 4'b0101);

      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         a[19:16] = 4'($urandom_range(0, 5));
         d = $urandom_range(0, 11);
         xfer(a, 1'($urandom), $urandom, d, $urandom, 4'($urandom));
      end

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         a[19:16] = 4'($urandom_range(4, 15));
         xfer(a, 1'($urandom), $urandom, 0, 32'h0, 4'b0000);
      end
      chk("err_cnt_saturated", 64'(err_cnt), 64'd255);

      @(negedge clk);
      m_stb = 1'b1; m_we = 1'b0; m_addr = 32'h0001_0020; m_dat_i = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_stb", 64'(s_stb), 64'b0010);
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      m_stb = 1'b0;
      reset = 1'b0;
      mdat_model = '0;
      errcnt_model = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_resp_after_reset", 64'({m_ack, m_err, s_stb}), 64'd0);
      end
      xfer(32'h0001_0000, 1'b0, 32'h0, 1, 32'h600D_DA7A, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
